// File: rtl/uart_ctrl.sv
// Memory-mapped UART: TXDATA/STATUS/RXDATA/DIV registers, 8N1 framing, programmable divisor.
// Define UART_RX_EN to build the receiver; without it the block is transmit-only.
module uart_ctrl #(
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  uart_addr,
  input  logic        uart_wen,
  input  logic [31:0] uart_wdata,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic [1:0]  w_word;
  logic        w_wr_tx;
  logic        w_wr_div;
  logic [15:0] r_div;
  logic        w_tx_busy;
  logic [3:1]  w_st_rx;
  logic [7:0]  w_rx_byte;
  logic        w_unused;

  assign w_word   = uart_addr[3:2];
  assign w_wr_tx  = uart_wen && (w_word == 2'd0);
  assign w_wr_div = uart_wen && (w_word == 2'd3);
  assign w_unused = ^{uart_addr[1:0], uart_wdata[31:16], uart_rxd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_div <= BAUD_DIV_RST;
    else if (w_wr_div)
      r_div <= (uart_wdata[15:0] < 16'd4) ? 16'd4 : uart_wdata[15:0];
  end

  // ---------------- transmitter ----------------
  state_t      r_tx_state, w_tx_state_n;
  logic [15:0] r_tx_cnt, w_tx_cnt_n;
  logic [15:0] r_tx_div, w_tx_div_n;
  logic [2:0]  r_tx_bit, w_tx_bit_n;
  logic [7:0]  r_tx_shift, w_tx_shift_n;
  logic        w_tx_zero;

  assign w_tx_zero = (r_tx_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tx_state <= ST_IDLE;
    else
      r_tx_state <= w_tx_state_n;
  end

  always_ff @(posedge clk) begin
    r_tx_cnt   <= w_tx_cnt_n;
    r_tx_div   <= w_tx_div_n;
    r_tx_bit   <= w_tx_bit_n;
    r_tx_shift <= w_tx_shift_n;
  end

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt;
    w_tx_div_n   = r_tx_div;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    if (r_tx_state != ST_IDLE && !w_tx_zero)
      w_tx_cnt_n = r_tx_cnt - 16'd1;
    case (r_tx_state)
      ST_IDLE: begin
        if (w_wr_tx) begin
          w_tx_state_n = ST_START;
          w_tx_shift_n = uart_wdata[7:0];
          w_tx_div_n   = r_div;
          w_tx_cnt_n   = r_div - 16'd1;
        end
      end
      ST_START: begin
        if (w_tx_zero) begin
          w_tx_state_n = ST_DATA;
          w_tx_cnt_n   = r_tx_div - 16'd1;
          w_tx_bit_n   = 3'd0;
        end
      end
      ST_DATA: begin
        if (w_tx_zero) begin
          w_tx_cnt_n = r_tx_div - 16'd1;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_n = ST_STOP;
          end else begin
            w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
            w_tx_bit_n   = r_tx_bit + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tx_zero)
          w_tx_state_n = ST_IDLE;
      end
    endcase
  end

  // Line level derives from the state register, so reset drives it high immediately.
  always_comb begin
    case (r_tx_state)
      ST_START: uart_txd = 1'b0;
      ST_DATA:  uart_txd = r_tx_shift[0];
      default:  uart_txd = 1'b1;
    endcase
  end

  assign w_tx_busy  = (r_tx_state != ST_IDLE);
  assign uart_ready = ~w_tx_busy;

`ifdef UART_RX_EN
  // ---------------- receiver ----------------
  logic        w_wr_st;
  logic        w_wr_rxd;
  logic        r_rx_s1, r_rx_s2, r_rx_prev;
  state_t      r_rx_state, w_rx_state_n;
  logic [15:0] r_rx_cnt, w_rx_cnt_n;
  logic [15:0] r_rx_div, w_rx_div_n;
  logic [2:0]  r_rx_bit, w_rx_bit_n;
  logic [7:0]  r_rx_shift, w_rx_shift_n;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid, r_rx_ovr, r_rx_ferr;
  logic        w_rx_zero, w_store, w_ovr_set, w_ferr_set;
  logic        w_rx_valid_n, w_rx_ovr_n, w_rx_ferr_n;

  assign w_wr_st   = uart_wen && (w_word == 2'd1);
  assign w_wr_rxd  = uart_wen && (w_word == 2'd2);
  assign w_rx_zero = (r_rx_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= ST_IDLE;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s1    <= uart_rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_n;
      if (w_store)
        r_rx_data <= r_rx_shift;
      r_rx_valid <= w_rx_valid_n;
      r_rx_ovr   <= w_rx_ovr_n;
      r_rx_ferr  <= w_rx_ferr_n;
    end
  end

  always_ff @(posedge clk) begin
    r_rx_cnt   <= w_rx_cnt_n;
    r_rx_div   <= w_rx_div_n;
    r_rx_bit   <= w_rx_bit_n;
    r_rx_shift <= w_rx_shift_n;
  end

  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt;
    w_rx_div_n   = r_rx_div;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_store      = 1'b0;
    w_ovr_set    = 1'b0;
    w_ferr_set   = 1'b0;
    if (r_rx_state != ST_IDLE && !w_rx_zero)
      w_rx_cnt_n = r_rx_cnt - 16'd1;
    case (r_rx_state)
      ST_IDLE: begin
        if (r_rx_prev && !r_rx_s2) begin
          w_rx_state_n = ST_START;
          w_rx_div_n   = r_div;
          w_rx_cnt_n   = {1'b0, r_div[15:1]} - 16'd1;
        end
      end
      ST_START: begin
        if (w_rx_zero) begin
          if (r_rx_s2) begin
            w_rx_state_n = ST_IDLE;
          end else begin
            w_rx_state_n = ST_DATA;
            w_rx_cnt_n   = r_rx_div - 16'd1;
            w_rx_bit_n   = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (w_rx_zero) begin
          w_rx_shift_n = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_cnt_n   = r_rx_div - 16'd1;
          if (r_rx_bit == 3'd7)
            w_rx_state_n = ST_STOP;
          else
            w_rx_bit_n = r_rx_bit + 3'd1;
        end
      end
      ST_STOP: begin
        if (w_rx_zero) begin
          w_rx_state_n = ST_IDLE;
          if (!r_rx_s2)
            w_ferr_set = 1'b1;
          else if (r_rx_valid)
            w_ovr_set = 1'b1;
          else
            w_store = 1'b1;
        end
      end
    endcase
  end

  // Sets are applied after clears so a same-cycle set always wins.
  always_comb begin
    w_rx_valid_n = r_rx_valid;
    w_rx_ovr_n   = r_rx_ovr;
    w_rx_ferr_n  = r_rx_ferr;
    if (w_wr_rxd)
      w_rx_valid_n = 1'b0;
    if (w_store)
      w_rx_valid_n = 1'b1;
    if (w_wr_st && uart_wdata[2])
      w_rx_ovr_n = 1'b0;
    if (w_ovr_set)
      w_rx_ovr_n = 1'b1;
    if (w_wr_st && uart_wdata[3])
      w_rx_ferr_n = 1'b0;
    if (w_ferr_set)
      w_rx_ferr_n = 1'b1;
  end

  assign w_st_rx   = {r_rx_ferr, r_rx_ovr, r_rx_valid};
  assign w_rx_byte = r_rx_data;
`else
  assign w_st_rx   = 3'b000;
  assign w_rx_byte = 8'd0;
`endif

  always_comb begin
    uart_rdata = 32'd0;
    case (w_word)
      2'd1:    uart_rdata = {28'd0, w_st_rx, w_tx_busy};
      2'd2:    uart_rdata = {24'd0, w_rx_byte};
      2'd3:    uart_rdata = {16'd0, r_div};
      default: uart_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: register table, TX/RX frame scoreboards, reset abort.
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  uart_addr = 4'd0;
  logic        uart_wen = 1'b0;
  logic [31:0] uart_wdata = 32'd0;
  logic [31:0] uart_rdata;
  logic        uart_ready;
  logic        uart_txd;
  logic        uart_rxd = 1'b1;

  int checks = 0;
  int failures = 0;

  logic       q_tx[$];
  logic [7:0] q_rx[$];

  typedef struct {
    logic [3:0]  addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_ready;
  } vec_t;

  vec_t vt [14];

  uart_ctrl #(.BAUD_DIV_RST(16'd434)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_addr  (uart_addr),
    .uart_wen   (uart_wen),
    .uart_wdata (uart_wdata),
    .uart_rdata (uart_rdata),
    .uart_ready (uart_ready),
    .uart_txd   (uart_txd),
    .uart_rxd   (uart_rxd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    uart_addr  = a;
    uart_wdata = d;
    uart_wen   = 1'b1;
    @(negedge clk);
    uart_wen   = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    uart_addr = a;
    #1;
    chk(name, uart_rdata, exp);
  endtask

  // Expected line levels are queued when the write is issued and popped mid-bit.
  task automatic tx_frame(input logic [7:0] d, input bit dup);
    int  low;
    bit  done;
    bit  quiet;
    low  = 0;
    done = 1'b0;
    q_tx.push_back(1'b0);
    for (int b = 0; b < 8; b++) q_tx.push_back(d[b]);
    q_tx.push_back(1'b1);
    wr(4'h0, {24'd0, d});
    for (int i = 0; i < 200 && !done; i++) begin
      if (uart_ready == 1'b0) low++;
      else done = 1'b1;
      if (!done && (i % 8) == 4 && q_tx.size() > 0)
        chk("tx_bit", {31'd0, uart_txd}, {31'd0, q_tx.pop_front()});
      if (dup && i == 20) begin
        uart_addr  = 4'h0;
        uart_wdata = 32'hFF;
        uart_wen   = 1'b1;
      end
      if (dup && i == 21) uart_wen = 1'b0;
      @(negedge clk);
    end
    chk("tx_busy_cycles", low, 80);
    chk("tx_bits_left", q_tx.size(), 0);
    q_tx.delete();
    if (dup) begin
      quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
        if (uart_txd !== 1'b1 || uart_ready !== 1'b1) quiet = 1'b0;
        @(negedge clk);
      end
      chk("tx_no_restart", {31'd0, quiet}, 32'd1);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stopb);
    logic [9:0] bits;
    bits = {stopb, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      repeat (8) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    vt[0]  = '{4'h0, 1'b0, 32'h0,     32'h0,    1'b1};
    vt[1]  = '{4'h4, 1'b0, 32'h0,     32'h0,    1'b1};
    vt[2]  = '{4'h8, 1'b0, 32'h0,     32'h0,    1'b1};
    vt[3]  = '{4'hC, 1'b0, 32'h0,     32'd434,  1'b1};
    vt[4]  = '{4'hC, 1'b1, 32'h2,     32'd434,  1'b1};
    vt[5]  = '{4'hC, 1'b0, 32'h0,     32'h4,    1'b1};
    vt[6]  = '{4'hC, 1'b1, 32'h12345, 32'h4,    1'b1};
    vt[7]  = '{4'hC, 1'b0, 32'h0,     32'h2345, 1'b1};
    vt[8]  = '{4'h4, 1'b1, 32'hF,     32'h0,    1'b1};
    vt[9]  = '{4'h4, 1'b0, 32'h0,     32'h0,    1'b1};
    vt[10] = '{4'h8, 1'b1, 32'hFF,    32'h0,    1'b1};
    vt[11] = '{4'h8, 1'b0, 32'h0,     32'h0,    1'b1};
    vt[12] = '{4'hC, 1'b1, 32'h8,     32'h2345, 1'b1};
    vt[13] = '{4'hC, 1'b0, 32'h0,     32'h8,    1'b1};

    repeat (3) @(negedge clk);
    chk("reset_txd", {31'd0, uart_txd}, 32'd1);
    chk("reset_ready", {31'd0, uart_ready}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      uart_addr  = vt[i].addr;
      uart_wen   = vt[i].wen;
      uart_wdata = vt[i].wdata;
      #1;
      chk($sformatf("vec%0d_rdata", i), uart_rdata, vt[i].exp_rdata);
      chk($sformatf("vec%0d_ready", i), {31'd0, uart_ready}, {31'd0, vt[i].exp_ready});
    end
    @(negedge clk);
    uart_wen = 1'b0;

    tx_frame(8'h5A, 1'b0);
    rd_chk("status_after_tx", 4'h4, 32'h0);
    tx_frame(8'hC3, 1'b1);
    rd_chk("status_after_dup", 4'h4, 32'h0);

`ifdef UART_RX_EN
    q_rx.push_back(8'hA5);
    send_rx(8'hA5, 1'b1);
    rd_chk("rx_status_valid", 4'h4, 32'h2);
    rd_chk("rx_data_a5", 4'h8, {24'd0, q_rx.pop_front()});
    wr(4'h8, 32'h0);
    rd_chk("rx_status_cleared", 4'h4, 32'h0);

    q_rx.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd_chk("rx_data_kept", 4'h8, {24'd0, q_rx.pop_front()});
    rd_chk("rx_status_overrun", 4'h4, 32'h6);
    wr(4'h4, 32'h4);
    rd_chk("rx_status_w1c", 4'h4, 32'h2);
    wr(4'h8, 32'h0);

    send_rx(8'h3C, 1'b0);
    rd_chk("rx_status_frame", 4'h4, 32'h8);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    rd_chk("rx_status_glitch", 4'h4, 32'h8);
    wr(4'h4, 32'h8);
    rd_chk("rx_status_ferr_clr", 4'h4, 32'h0);
`else
    send_rx(8'hA5, 1'b1);
    rd_chk("norx_status", 4'h4, 32'h0);
    rd_chk("norx_data", 4'h8, 32'h0);
`endif

    wr(4'h0, 32'h5A);
    uart_addr = 4'hC;
    repeat (30) @(negedge clk);
    chk("pre_reset_busy", {31'd0, uart_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_txd", {31'd0, uart_txd}, 32'd1);
    chk("abort_ready", {31'd0, uart_ready}, 32'd1);
    chk("abort_div", uart_rdata, 32'd434);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    rd_chk("div_after_reset", 4'hC, 32'd434);
    chk("idle_txd_after_reset", {31'd0, uart_txd}, 32'd1);
    rd_chk("status_after_reset", 4'h4, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
